// File: rtl/keycode_if.sv
// Scan-code input, CPU read handshake and status outputs of the keycode decoder.
interface keycode_if;
  logic       scan_valid;
  logic [7:0] scan_code;
  logic       rd_en;
  logic [7:0] ascii_out;
  logic       ascii_valid;
  logic       fifo_full;
  logic       overflow;
  logic       caps_lock;
  logic       shift_held;

  modport master (
    output scan_valid, scan_code, rd_en,
    input  ascii_out, ascii_valid, fifo_full, overflow, caps_lock, shift_held
  );

  modport slave (
    input  scan_valid, scan_code, rd_en,
    output ascii_out, ascii_valid, fifo_full, overflow, caps_lock, shift_held
  );
endinterface

// File: rtl/keycode_decoder.sv
// PS/2 set-2 scan-code stream decoder with prefix tracking, modifiers and a FWFT ASCII FIFO.
module keycode_decoder #(
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter logic [7:0]  UNKNOWN_CHAR = 8'h2A,
  parameter bit          DROP_UNKNOWN = 1'b0
) (
  input  logic      clk,
  input  logic      rst_n,
  keycode_if.slave  bus
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

  state_t         state_q, state_d;
  logic           lshift_q, lshift_d, rshift_q, rshift_d;
  logic           caps_q, caps_d, caps_held_q, caps_held_d;
  logic           shift_q;
  logic           push_req;
  logic [7:0]     push_data;
  logic [7:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [7:0]     head_q, head_d;
  logic           valid_q, full_q, overflow_q;
  logic           pop, push_ok, full_now;
  logic [8:0]     mapped;

  // US-layout lookup; returns {hit, char}. Letters flip case on upper, symbols on shift.
  function automatic logic [8:0] map_code(input logic [7:0] code, input logic shift,
                                          input logic upper);
    logic [1:0] kind;
    logic [7:0] lo, hi;
    kind = 2'd2;
    lo   = 8'h00;
    hi   = 8'h00;
    case (code)
      8'h1C: begin kind = 2'd1; lo = 8'h61; end
      8'h32: begin kind = 2'd1; lo = 8'h62; end
      8'h21: begin kind = 2'd1; lo = 8'h63; end
      8'h23: begin kind = 2'd1; lo = 8'h64; end
      8'h24: begin kind = 2'd1; lo = 8'h65; end
      8'h2B: begin kind = 2'd1; lo = 8'h66; end
      8'h34: begin kind = 2'd1; lo = 8'h67; end
      8'h33: begin kind = 2'd1; lo = 8'h68; end
      8'h43: begin kind = 2'd1; lo = 8'h69; end
      8'h3B: begin kind = 2'd1; lo = 8'h6A; end
      8'h42: begin kind = 2'd1; lo = 8'h6B; end
      8'h4B: begin kind = 2'd1; lo = 8'h6C; end
      8'h3A: begin kind = 2'd1; lo = 8'h6D; end
      8'h31: begin kind = 2'd1; lo = 8'h6E; end
      8'h44: begin kind = 2'd1; lo = 8'h6F; end
      8'h4D: begin kind = 2'd1; lo = 8'h70; end
      8'h15: begin kind = 2'd1; lo = 8'h71; end
      8'h2D: begin kind = 2'd1; lo = 8'h72; end
      8'h1B: begin kind = 2'd1; lo = 8'h73; end
      8'h2C: begin kind = 2'd1; lo = 8'h74; end
      8'h3C: begin kind = 2'd1; lo = 8'h75; end
      8'h2A: begin kind = 2'd1; lo = 8'h76; end
      8'h1D: begin kind = 2'd1; lo = 8'h77; end
      8'h22: begin kind = 2'd1; lo = 8'h78; end
      8'h35: begin kind = 2'd1; lo = 8'h79; end
      8'h1A: begin kind = 2'd1; lo = 8'h7A; end
      8'h45: begin lo = 8'h30; hi = 8'h29; end
      8'h16: begin lo = 8'h31; hi = 8'h21; end
      8'h1E: begin lo = 8'h32; hi = 8'h40; end
      8'h26: begin lo = 8'h33; hi = 8'h23; end
      8'h25: begin lo = 8'h34; hi = 8'h24; end
      8'h2E: begin lo = 8'h35; hi = 8'h25; end
      8'h36: begin lo = 8'h36; hi = 8'h5E; end
      8'h3D: begin lo = 8'h37; hi = 8'h26; end
      8'h3E: begin lo = 8'h38; hi = 8'h2A; end
      8'h46: begin lo = 8'h39; hi = 8'h28; end
      8'h0E: begin lo = 8'h60; hi = 8'h7E; end
      8'h4E: begin lo = 8'h2D; hi = 8'h5F; end
      8'h55: begin lo = 8'h3D; hi = 8'h2B; end
      8'h54: begin lo = 8'h5B; hi = 8'h7B; end
      8'h5B: begin lo = 8'h5D; hi = 8'h7D; end
      8'h5D: begin lo = 8'h5C; hi = 8'h7C; end
      8'h4C: begin lo = 8'h3B; hi = 8'h3A; end
      8'h52: begin lo = 8'h27; hi = 8'h22; end
      8'h41: begin lo = 8'h2C; hi = 8'h3C; end
      8'h49: begin lo = 8'h2E; hi = 8'h3E; end
      8'h4A: begin lo = 8'h2F; hi = 8'h3F; end
      8'h29: begin kind = 2'd3; lo = 8'h20; end
      8'h5A: begin kind = 2'd3; lo = 8'h0D; end
      8'h66: begin kind = 2'd3; lo = 8'h08; end
      8'h0D: begin kind = 2'd3; lo = 8'h09; end
      8'h76: begin kind = 2'd3; lo = 8'h1B; end
      default: kind = 2'd0;
    endcase
    case (kind)
      2'd1:    return {1'b1, upper ? (lo - 8'h20) : lo};
      2'd2:    return {1'b1, shift ? hi : lo};
      2'd3:    return {1'b1, lo};
      default: return 9'd0;
    endcase
  endfunction

  assign mapped = map_code(bus.scan_code, shift_q, shift_q ^ caps_q);

  // Prefix FSM next state, modifier updates and push request.
  always_comb begin
    state_d     = state_q;
    lshift_d    = lshift_q;
    rshift_d    = rshift_q;
    caps_d      = caps_q;
    caps_held_d = caps_held_q;
    push_req    = 1'b0;
    push_data   = 8'h00;
    if (bus.scan_valid) begin
      case (state_q)
        S_IDLE: begin
          case (bus.scan_code)
            8'hE0: state_d = S_EXT;
            8'hF0: state_d = S_BRK;
            8'h12: lshift_d = 1'b1;
            8'h59: rshift_d = 1'b1;
            8'h58: begin
              if (!caps_held_q) caps_d = ~caps_q;
              caps_held_d = 1'b1;
            end
            default: begin
              if (mapped[8]) begin
                push_req  = 1'b1;
                push_data = mapped[7:0];
              end else if (!DROP_UNKNOWN) begin
                push_req  = 1'b1;
                push_data = UNKNOWN_CHAR;
              end
            end
          endcase
        end
        S_EXT: begin
          state_d = S_IDLE;
          case (bus.scan_code)
            8'hF0: state_d = S_EXT_BRK;
            8'h5A: begin push_req = 1'b1; push_data = 8'h0D; end
            8'h4A: begin push_req = 1'b1; push_data = 8'h2F; end
            default: ;
          endcase
        end
        S_BRK: begin
          state_d = S_IDLE;
          case (bus.scan_code)
            8'h12:   lshift_d    = 1'b0;
            8'h59:   rshift_d    = 1'b0;
            8'h58:   caps_held_d = 1'b0;
            default: ;
          endcase
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FIFO bookkeeping; the head register is precomputed so ascii_out stays registered.
  always_comb begin
    pop      = bus.rd_en && valid_q;
    full_now = (count_q == CW'(FIFO_DEPTH));
    push_ok  = push_req && (!full_now || pop);
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(push_ok) - CW'(pop);
    head_d   = 8'h00;
    if (count_d != '0) begin
      if (push_ok && (rd_ptr_d == wr_ptr_q)) head_d = push_data;
      else                                    head_d = mem[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      lshift_q    <= 1'b0;
      rshift_q    <= 1'b0;
      shift_q     <= 1'b0;
      caps_q      <= 1'b0;
      caps_held_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      head_q      <= 8'h00;
      valid_q     <= 1'b0;
      full_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      lshift_q    <= lshift_d;
      rshift_q    <= rshift_d;
      shift_q     <= lshift_d | rshift_d;
      caps_q      <= caps_d;
      caps_held_q <= caps_held_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      head_q      <= head_d;
      valid_q     <= (count_d != '0);
      full_q      <= (count_d == CW'(FIFO_DEPTH));
      if (push_req && !push_ok) overflow_q <= 1'b1;
    end
  end

  assign bus.ascii_out   = head_q;
  assign bus.ascii_valid = valid_q;
  assign bus.fifo_full   = full_q;
  assign bus.overflow    = overflow_q;
  assign bus.caps_lock   = caps_q;
  assign bus.shift_held  = shift_q;
endmodule
